// File: rtl/twiddle_gen_if.sv
// Stream interface between the SDF stage feeding twiddle_gen and the complex multiplier.
// DATA_WIDTH / SHIFT_AMOUNT fall back to 16 / 15 when the build does not supply them.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef SHIFT_AMOUNT
`define SHIFT_AMOUNT 15
`endif

interface twiddle_gen_if #(
  parameter int LOG2N   = 6,
  parameter int STAGE_W = 4
);
  typedef struct packed {
    logic signed [`DATA_WIDTH-1:0] data_r;
    logic signed [`DATA_WIDTH-1:0] data_i;
  } DATA_SAMPLE;

  logic               in_valid;
  logic               in_ready;
  logic               in_sof;
  DATA_SAMPLE         in_data;
  logic [STAGE_W-1:0] cfg_stage;
`ifdef TWIDDLE_CONJ_EN
  logic               inv;
`endif
  logic               out_valid;
  logic               out_ready;
  DATA_SAMPLE         out_data;
  DATA_SAMPLE         out_tw;
  logic [LOG2N-1:0]   out_idx;
  logic               out_sof;
  logic               out_eof;

  modport master (
    output in_valid, in_sof, in_data, cfg_stage, out_ready,
`ifdef TWIDDLE_CONJ_EN
    output inv,
`endif
    input  in_ready, out_valid, out_data, out_tw, out_idx, out_sof, out_eof
  );

  modport slave (
    input  in_valid, in_sof, in_data, cfg_stage, out_ready,
`ifdef TWIDDLE_CONJ_EN
    input  inv,
`endif
    output in_ready, out_valid, out_data, out_tw, out_idx, out_sof, out_eof
  );
endinterface

// File: rtl/twiddle_gen.sv
// Radix-2 DIF SDF twiddle sequencer: tags each sample with its frame index and W_N^e.
// Define TWIDDLE_CONJ_EN to add the inv input, which conjugates twiddles for an IFFT.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef SHIFT_AMOUNT
`define SHIFT_AMOUNT 15
`endif

module twiddle_gen #(
  parameter int LOG2N   = 6,
  parameter int STAGE_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  twiddle_gen_if.slave bus
);
  localparam int N  = 1 << LOG2N;
  localparam int QN = N / 4;
  localparam int DW = `DATA_WIDTH;
  localparam int IW = LOG2N - 1;
  localparam logic [LOG2N-1:0] HALF_N = LOG2N'(N / 2);

  typedef struct packed {
    logic signed [DW-1:0] data_r;
    logic signed [DW-1:0] data_i;
  } DATA_SAMPLE;

  // Elaboration-time cosine (Taylor series on [0, pi/2]), rounded and saturated to DW.
  function automatic int cos_q(input int i);
    real x, term, acc, scale, v;
    x     = 2.0 * 3.14159265358979323846 * $itor(i) / $itor(N);
    acc   = 1.0;
    term  = 1.0;
    for (int n = 1; n <= 14; n++) begin
      term = -term * x * x / $itor((2 * n - 1) * (2 * n));
      acc  = acc + term;
    end
    scale = 1.0;
    for (int j = 0; j < `SHIFT_AMOUNT; j++) scale = scale * 2.0;
    v = acc * scale + 0.5;
    if (v >= $itor((1 << (DW - 1)) - 1)) return (1 << (DW - 1)) - 1;
    return $rtoi(v);
  endfunction

  logic signed [DW-1:0] rom [0:QN];
  for (genvar g = 0; g <= QN; g++) begin : g_rom
    localparam int CV = cos_q(g);
    assign rom[g] = DW'(CV);
  end

  logic               out_valid_q;
  DATA_SAMPLE         out_data_q;
  DATA_SAMPLE         out_tw_q;
  logic [LOG2N-1:0]   out_idx_q;
  logic               out_sof_q;
  logic               out_eof_q;
  logic [LOG2N-1:0]   cnt;
  logic [STAGE_W-1:0] s_lat;

  logic               accept;
  logic [STAGE_W-1:0] s_cfg;
  logic [STAGE_W-1:0] s_use;
  logic [LOG2N-1:0]   k_use;
  logic [LOG2N-1:0]   h_bit;
  logic [LOG2N-1:0]   h_mask;
  logic [LOG2N-1:0]   e;
  logic [1:0]         q;
  logic [IW-1:0]      r;
  logic [IW-1:0]      rc;
  logic signed [DW-1:0] c_r;
  logic signed [DW-1:0] c_c;
  DATA_SAMPLE         tw;

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign s_cfg         = (bus.cfg_stage >= STAGE_W'(LOG2N)) ? STAGE_W'(LOG2N - 1) : bus.cfg_stage;
  assign s_use         = bus.in_sof ? s_cfg : s_lat;
  assign k_use         = bus.in_sof ? '0 : cnt;

`ifdef TWIDDLE_CONJ_EN
  logic inv_lat;
  logic inv_use;
  assign inv_use = bus.in_sof ? bus.inv : inv_lat;
`endif

  // h = N >> (s+1) is a single bit, so (k mod M) >= h is just that bit of k.
  always_comb begin
    h_bit  = HALF_N >> s_use;
    h_mask = h_bit - LOG2N'(1);
    e      = ((k_use & h_bit) != '0) ? LOG2N'((k_use & h_mask) << s_use) : '0;
    q      = e[LOG2N-1 -: 2];
    r      = {1'b0, e[LOG2N-3:0]};
    rc     = IW'(QN) - r;
    c_r    = rom[r];
    c_c    = rom[rc];
    tw     = '0;
    case (q)
      2'd0: begin tw.data_r = c_r;  tw.data_i = -c_c; end
      2'd1: begin tw.data_r = -c_c; tw.data_i = -c_r; end
      2'd2: begin tw.data_r = -c_r; tw.data_i = c_c;  end
      default: begin tw.data_r = c_c; tw.data_i = c_r; end
    endcase
`ifdef TWIDDLE_CONJ_EN
    if (inv_use) tw.data_i = -tw.data_i;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tw_q    <= '0;
      out_idx_q   <= '0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      cnt         <= '0;
      s_lat       <= '0;
`ifdef TWIDDLE_CONJ_EN
      inv_lat     <= 1'b0;
`endif
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.in_data;
      out_tw_q    <= tw;
      out_idx_q   <= k_use;
      out_sof_q   <= (k_use == '0);
      out_eof_q   <= (k_use == '1);
      cnt         <= k_use + LOG2N'(1);
      // Frame start, explicit or by wrap, is the only point the stage config is taken.
      if (bus.in_sof || cnt == '1) begin
        s_lat   <= s_cfg;
`ifdef TWIDDLE_CONJ_EN
        inv_lat <= bus.inv;
`endif
      end
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_tw    = out_tw_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.out_eof   = out_eof_q;
endmodule
